// File: rtl/ori_hist_peak.sv
// Dominant-orientation histogram: accumulates a window of (bin, magnitude) samples into 32 bins,
// scans for the peak and hands it downstream. Optional macro ORI_HIST_SMOOTH_EN: [1 2 1]/4 scan.
module ori_hist_peak #(
    parameter int unsigned MAG_W       = 8,
    parameter int unsigned ACC_W       = 16,
    parameter int unsigned NUM_SAMPLES = 256
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [4:0]       i_in_bin,
    input  logic [MAG_W-1:0] i_in_mag,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [4:0]       o_peak_bin,
    output logic [ACC_W-1:0] o_peak_val,
    output logic             o_busy
);

    localparam int unsigned CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam int unsigned SUM_W = ((ACC_W > MAG_W) ? ACC_W : MAG_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_SAMPLES);
    localparam logic [SUM_W-1:0] SAT_MAX  = SUM_W'({ACC_W{1'b1}});

    typedef enum logic [2:0] {StIdle, StClear, StAccum, StScan, StDone} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [5:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_hist [32];
    logic [ACC_W-1:0] r_cand_val;
    logic [ACC_W-1:0] r_max_val;
    logic [4:0]       r_max_bin;
    logic [4:0]       r_peak_bin;
    logic [ACC_W-1:0] r_peak_val;

    logic             w_in_ready;
    logic             w_fire;
    logic [SUM_W-1:0] w_sum;
    logic [ACC_W-1:0] w_hist_upd;
    logic [4:0]       w_scan_bin;
    logic [ACC_W-1:0] w_cand;
    logic             w_take;
    logic [ACC_W-1:0] w_max_nxt;
    logic [4:0]       w_bin_nxt;

    assign w_in_ready = (r_state == StAccum) && (r_cnt < CNT_FULL);
    assign w_fire     = i_in_valid && w_in_ready;

    assign w_sum      = SUM_W'(r_hist[i_in_bin]) + SUM_W'(i_in_mag);
    assign w_hist_upd = (w_sum > SAT_MAX) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

    assign w_scan_bin = r_idx[4:0];

`ifdef ORI_HIST_SMOOTH_EN
    logic [4:0]       w_prev_bin;
    logic [4:0]       w_next_bin;
    logic [ACC_W+1:0] w_smooth;

    // 5-bit index arithmetic gives the circular wrap 31 <-> 0 for free.
    assign w_prev_bin = w_scan_bin - 5'd1;
    assign w_next_bin = w_scan_bin + 5'd1;
    assign w_smooth   = {2'b00, r_hist[w_prev_bin]} + {1'b0, r_hist[w_scan_bin], 1'b0}
                      + {2'b00, r_hist[w_next_bin]};
    assign w_cand     = ACC_W'(w_smooth >> 2);
`else
    assign w_cand     = r_hist[w_scan_bin];
`endif

    // Candidate is registered, so the compare stage trails the read by one cycle (bin = idx-1).
    assign w_take    = (r_idx == 6'd1) || (r_cand_val > r_max_val);
    assign w_max_nxt = w_take ? r_cand_val : r_max_val;
    assign w_bin_nxt = w_take ? (w_scan_bin - 5'd1) : r_max_bin;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_nxt = StClear;
            StClear: if (r_idx == 6'd31) w_state_nxt = StAccum;
            StAccum: if (w_fire && (r_cnt == CNT_LAST)) w_state_nxt = StScan;
            StScan:  if (r_idx == 6'd32) w_state_nxt = StDone;
            StDone:  if (i_out_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_idx      <= '0;
            r_cnt      <= '0;
            r_cand_val <= '0;
            r_max_val  <= '0;
            r_max_bin  <= '0;
            r_peak_bin <= '0;
            r_peak_val <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_idx <= '0;
                    r_cnt <= '0;
                end
                StClear: begin
                    r_idx <= (r_idx == 6'd31) ? 6'd0 : r_idx + 6'd1;
                end
                StAccum: begin
                    if (w_fire) r_cnt <= r_cnt + 1'b1;
                end
                StScan: begin
                    r_idx      <= r_idx + 6'd1;
                    r_cand_val <= w_cand;
                    if (r_idx != 6'd0) begin
                        r_max_val <= w_max_nxt;
                        r_max_bin <= w_bin_nxt;
                    end
                    if (r_idx == 6'd32) begin
                        r_peak_val <= w_max_nxt;
                        r_peak_bin <= w_bin_nxt;
                    end
                end
                StDone: begin
                    r_idx <= '0;
                    r_cnt <= '0;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    // Histogram storage is deliberately unreset; CLEAR wipes it at the start of every window.
    always_ff @(posedge i_clk) begin
        if (r_state == StClear) begin
            r_hist[w_scan_bin] <= '0;
        end else if (w_fire) begin
            r_hist[i_in_bin] <= w_hist_upd;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = (r_state == StDone);
    assign o_busy      = (r_state != StIdle);
    assign o_peak_bin  = r_peak_bin;
    assign o_peak_val  = r_peak_val;

endmodule

// File: tb/tb_ori_hist_peak.sv
// Scoreboard bench for ori_hist_peak: two instances (ACC_W 16 and 12) share stimulus; a monitor
// pops expected peaks from per-instance queues on each result handshake.
module tb_ori_hist_peak;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [4:0]  in_bin;
    logic [7:0]  in_mag;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_busy;
    logic [4:0]  a_peak_bin;
    logic [15:0] a_peak_val;
    logic        b_in_ready, b_out_valid, b_busy;
    logic [4:0]  b_peak_bin;
    logic [11:0] b_peak_val;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;

    typedef struct {
        int     bin;
        longint val;
    } exp_t;

    exp_t        exp_a[$];
    exp_t        exp_b[$];
    int          smp_bin[$];
    int          smp_mag[$];

    bit          held[2];
    logic [4:0]  sbin[2];
    logic [15:0] sval[2];

    ori_hist_peak #(.MAG_W(8), .ACC_W(16), .NUM_SAMPLES(256)) u_dut_a (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_in_valid (in_valid),
        .o_in_ready (a_in_ready),
        .i_in_bin   (in_bin),
        .i_in_mag   (in_mag),
        .o_out_valid(a_out_valid),
        .i_out_ready(out_ready),
        .o_peak_bin (a_peak_bin),
        .o_peak_val (a_peak_val),
        .o_busy     (a_busy)
    );

    ori_hist_peak #(.MAG_W(8), .ACC_W(12), .NUM_SAMPLES(256)) u_dut_b (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_in_valid (in_valid),
        .o_in_ready (b_in_ready),
        .i_in_bin   (in_bin),
        .i_in_mag   (in_mag),
        .o_out_valid(b_out_valid),
        .i_out_ready(out_ready),
        .o_peak_bin (b_peak_bin),
        .o_peak_val (b_peak_val),
        .o_busy     (b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: accumulate with saturation, optional circular smoothing, first strict maximum.
    function automatic void model(input int accw, output int pbin, output longint pval);
        longint h[32];
        longint s[32];
        longint mx;
        mx = (longint'(1) << accw) - 1;
        for (int i = 0; i < 32; i++) h[i] = 0;
        for (int k = 0; k < smp_bin.size(); k++) begin
            h[smp_bin[k]] = h[smp_bin[k]] + smp_mag[k];
            if (h[smp_bin[k]] > mx) h[smp_bin[k]] = mx;
        end
        for (int i = 0; i < 32; i++) begin
`ifdef ORI_HIST_SMOOTH_EN
            s[i] = ((h[(i + 31) % 32] + 2 * h[i] + h[(i + 1) % 32]) / 4) & mx;
`else
            s[i] = h[i];
`endif
        end
        pbin = 0;
        pval = s[0];
        for (int i = 1; i < 32; i++) begin
            if (s[i] > pval) begin
                pbin = i;
                pval = s[i];
            end
        end
    endfunction

    task automatic mon(input int d, input string tag, input logic ov, input logic [4:0] pb,
                       input logic [15:0] pv);
        exp_t e;
        if (!ov) begin
            held[d] = 1'b0;
            return;
        end
        if (held[d]) begin
            chk({tag, "_stable_bin"}, 64'(pb), 64'(sbin[d]));
            chk({tag, "_stable_val"}, 64'(pv), 64'(sval[d]));
        end
        held[d] = 1'b1;
        sbin[d] = pb;
        sval[d] = pv;
        if (out_ready) begin
            held[d] = 1'b0;
            if ((d == 0 && exp_a.size() == 0) || (d == 1 && exp_b.size() == 0)) begin
                n_checks++;
                n_err++;
                $display("FAIL %s_unexpected_result: got bin %0d val %0d, expected none",
                         tag, pb, pv);
            end else begin
                e = (d == 0) ? exp_a.pop_front() : exp_b.pop_front();
                chk({tag, "_peak_bin"}, 64'(pb), 64'(e.bin));
                chk({tag, "_peak_val"}, 64'(pv), 64'(e.val));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, "a", a_out_valid, a_peak_bin, a_peak_val);
            mon(1, "b", b_out_valid, b_peak_bin, {4'h0, b_peak_val});
        end else begin
            held[0] = 1'b0;
            held[1] = 1'b0;
        end
    end

    task automatic fill(input int bin, input int mag, input int n);
        for (int k = 0; k < n; k++) begin
            smp_bin.push_back(bin);
            smp_mag.push_back(mag);
        end
    endtask

    // vmode 0: in_valid held high, 1: alternate cycles, 2: random.
    task automatic run_window(input int vmode, input int hold, input bit pulse_start,
                              input int abort_at);
        int   k = 0;
        int   g = 0;
        int   c0;
        int   pb;
        longint pv;
        exp_t e;
        bit   v;
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        chk("busy_after_start", 64'(a_busy), 64'd1);
        while (k < smp_bin.size() && g < 4000 && (abort_at == 0 || k < abort_at)) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = g[0];
                default: v = 1'($urandom_range(0, 1));
            endcase
            in_valid = v;
            in_bin   = 5'(smp_bin[k]);
            in_mag   = 8'(smp_mag[k]);
            if (v && a_in_ready) k++;
            tick();
            g++;
        end
        if (abort_at != 0 && k == abort_at) begin
            rst_n = 1'b0;
            tick();
            rst_n    = 1'b1;
            in_valid = 1'b0;
            chk("rst_in_ready", 64'(a_in_ready), 64'd0);
            chk("rst_out_valid", 64'(a_out_valid), 64'd0);
            chk("rst_busy_a", 64'(a_busy), 64'd0);
            chk("rst_busy_b", 64'(b_busy), 64'd0);
            chk("rst_peak_bin", 64'(a_peak_bin), 64'd0);
            chk("rst_peak_val", 64'(a_peak_val), 64'd0);
            return;
        end
        chk("feed_count", 64'(k), 64'(smp_bin.size()));
        if (k != smp_bin.size()) return;
        model(16, pb, pv);
        e.bin = pb; e.val = pv;
        exp_a.push_back(e);
        model(12, pb, pv);
        e.bin = pb; e.val = pv;
        exp_b.push_back(e);
        // A sample offered after the window closes must not be taken.
        in_valid = 1'b1;
        in_bin   = 5'($urandom_range(0, 31));
        in_mag   = 8'd255;
        chk("in_ready_low_after_window", 64'(a_in_ready), 64'd0);
        g = 0;
        while (!a_out_valid && g < 400) begin
            tick();
            g++;
        end
        in_valid = 1'b0;
        chk("out_valid_a", 64'(a_out_valid), 64'd1);
        chk("out_valid_b", 64'(b_out_valid), 64'd1);
        if (vmode == 0) chk("latency", 64'(cyc - c0), 64'd321);
        for (int h = 0; h < hold; h++) begin
            start = pulse_start && (h == hold / 2);
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_after_hs", 64'(a_out_valid), 64'd0);
        chk("busy_after_hs", 64'(a_busy), 64'd0);
        tick();
        chk("idle_holds", 64'(a_busy | b_busy), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_bin    = '0;
        in_mag    = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        chk("reset_in_ready", 64'(a_in_ready), 64'd0);
        chk("reset_out_valid", 64'(a_out_valid), 64'd0);
        chk("reset_busy", 64'(a_busy | b_busy), 64'd0);
        chk("reset_peak_bin", 64'(a_peak_bin), 64'd0);
        chk("reset_peak_val", 64'(a_peak_val), 64'd0);
        rst_n = 1'b1;
        tick();

        smp_bin.delete(); smp_mag.delete();
        fill(7, 1, 256);
        run_window(0, 0, 1'b0, 0);

        smp_bin.delete(); smp_mag.delete();
        fill(20, 2, 128);
        fill(3, 2, 128);
        run_window(0, 0, 1'b0, 0);

        smp_bin.delete(); smp_mag.delete();
        fill(31, 255, 256);
        run_window(0, 0, 1'b0, 0);

        // Backpressure window: bin 5 collects 600, every other bin at most 9 * 60.
        smp_bin.delete(); smp_mag.delete();
        for (int k = 0, j = 0; k < 256; k++) begin
            if (k == 10 || k == 70 || k == 130 || k == 190) begin
                smp_bin.push_back(5);
                smp_mag.push_back(150);
            end else begin
                smp_bin.push_back((j % 31 < 5) ? j % 31 : j % 31 + 1);
                smp_mag.push_back(int'($urandom_range(0, 60)));
                j++;
            end
        end
        run_window(1, 10, 1'b1, 0);

        smp_bin.delete(); smp_mag.delete();
        fill(9, 50, 256);
        run_window(0, 0, 1'b0, 100);
        tick();
        smp_bin.delete(); smp_mag.delete();
        fill(0, 1, 256);
        run_window(0, 0, 1'b0, 0);

        smp_bin.delete(); smp_mag.delete();
        fill(0, 4, 256);
        run_window(0, 0, 1'b0, 0);

        for (int r = 0; r < 3; r++) begin
            smp_bin.delete(); smp_mag.delete();
            for (int k = 0; k < 256; k++) begin
                smp_bin.push_back(int'($urandom_range(0, 31)));
                smp_mag.push_back(int'($urandom_range(0, 255)));
            end
            run_window(2, int'($urandom_range(0, 5)), 1'b1, 0);
        end

        repeat (3) tick();
        chk("scoreboard_a_drained", 64'(exp_a.size()), 64'd0);
        chk("scoreboard_b_drained", 64'(exp_b.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
